// File: rtl/branch_resolve_ctrl.sv
// Conditional-branch sequencer: drives the shared comparator, resolves taken/not-taken,
// issues a fetch redirect handshake, then a timed flush. Keeps saturating branch statistics.
module branch_resolve_ctrl #(
  parameter int unsigned DATA_LENGTH  = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   br_valid,
  output logic                   br_ready,
  input  logic [2:0]             br_funct3,
  input  logic [DATA_LENGTH-1:0] br_rs1,
  input  logic [DATA_LENGTH-1:0] br_rs2,
  input  logic [DATA_LENGTH-1:0] br_pc,
  input  logic [DATA_LENGTH-1:0] br_imm,
  output logic [DATA_LENGTH-1:0] cmp_num1,
  output logic [DATA_LENGTH-1:0] cmp_num2,
  output logic                   cmp_BrUn,
  input  logic                   cmp_BrEq,
  input  logic                   cmp_BrLt,
  output logic                   redirect_valid,
  input  logic                   redirect_ready,
  output logic [DATA_LENGTH-1:0] redirect_pc,
  output logic                   flush,
  output logic                   br_done,
  output logic                   br_taken,
  output logic                   br_illegal,
  output logic [CNT_W-1:0]       cnt_branches,
  output logic [CNT_W-1:0]       cnt_taken
);

  // Flush counter holds cycles remaining after the current one.
  localparam int unsigned FcW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FcW-1:0] FlushLoad = FcW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  typedef enum logic [2:0] {StIdle, StCmp, StResolve, StRedir, StFlush} state_e;

  state_e                 state_q, state_d;
  logic [DATA_LENGTH-1:0] num1_q, num2_q, target_q;
  logic                   brun_q, eq_q, lt_q;
  logic [2:0]             funct3_q;
  logic [FcW-1:0]         fcnt_q;
  logic [CNT_W-1:0]       cnt_br_q, cnt_tk_q;
  logic                   taken, illegal;

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3_q)
      3'b000:          taken = eq_q;
      3'b001:          taken = ~eq_q;
      3'b100, 3'b110:  taken = lt_q;
      3'b101, 3'b111:  taken = ~lt_q;
      default:         illegal = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (br_valid) state_d = StCmp;
      StCmp:     state_d = StResolve;
      StResolve: state_d = taken ? StRedir : StIdle;
      StRedir: begin
        if (redirect_ready) state_d = (FLUSH_CYCLES > 0) ? StFlush : StIdle;
      end
      StFlush:   if (fcnt_q == '0) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Datapath and statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      num1_q   <= '0;
      num2_q   <= '0;
      brun_q   <= 1'b0;
      funct3_q <= 3'b000;
      target_q <= '0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      fcnt_q   <= '0;
      cnt_br_q <= '0;
      cnt_tk_q <= '0;
    end else begin
      if (state_q == StIdle && br_valid) begin
        num1_q   <= br_rs1;
        num2_q   <= br_rs2;
        brun_q   <= br_funct3[1];
        funct3_q <= br_funct3;
        target_q <= br_pc + br_imm;
      end
      if (state_q == StCmp) begin
        eq_q <= cmp_BrEq;
        lt_q <= cmp_BrLt;
      end
      if (state_q == StRedir && redirect_ready) begin
        fcnt_q <= FlushLoad;
      end else if (state_q == StFlush && fcnt_q != '0) begin
        fcnt_q <= fcnt_q - 1'b1;
      end
      if (state_q == StResolve) begin
        if (cnt_br_q != '1) cnt_br_q <= cnt_br_q + 1'b1;
        if (taken && cnt_tk_q != '1) cnt_tk_q <= cnt_tk_q + 1'b1;
      end
    end
  end

  // Outputs
  always_comb begin
    br_ready       = (state_q == StIdle);
    br_done        = (state_q == StResolve);
    br_taken       = (state_q == StResolve) && taken;
    br_illegal     = (state_q == StResolve) && illegal;
    redirect_valid = (state_q == StRedir);
    flush          = (state_q == StFlush);
  end

  assign cmp_num1     = num1_q;
  assign cmp_num2     = num2_q;
  assign cmp_BrUn     = brun_q;
  assign redirect_pc  = target_q;
  assign cnt_branches = cnt_br_q;
  assign cnt_taken    = cnt_tk_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl with a behavioural comparator attached.
module tb_branch_resolve_ctrl;

  localparam int unsigned Dl   = 32;
  localparam int unsigned CntW = 4;  // narrow counters keep the saturation run short

  logic            clk = 1'b0;
  logic            rst;
  logic            br_valid, br_ready;
  logic [2:0]      br_funct3;
  logic [Dl-1:0]   br_rs1, br_rs2, br_pc, br_imm;
  logic [Dl-1:0]   cmp_num1, cmp_num2;
  logic            cmp_BrUn, cmp_BrEq, cmp_BrLt;
  logic            redirect_valid, redirect_ready;
  logic [Dl-1:0]   redirect_pc;
  logic            flush, br_done, br_taken, br_illegal;
  logic [CntW-1:0] cnt_branches, cnt_taken;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(
    .DATA_LENGTH (Dl),
    .FLUSH_CYCLES(2),
    .CNT_W       (CntW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .br_valid      (br_valid),
    .br_ready      (br_ready),
    .br_funct3     (br_funct3),
    .br_rs1        (br_rs1),
    .br_rs2        (br_rs2),
    .br_pc         (br_pc),
    .br_imm        (br_imm),
    .cmp_num1      (cmp_num1),
    .cmp_num2      (cmp_num2),
    .cmp_BrUn      (cmp_BrUn),
    .cmp_BrEq      (cmp_BrEq),
    .cmp_BrLt      (cmp_BrLt),
    .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready),
    .redirect_pc   (redirect_pc),
    .flush         (flush),
    .br_done       (br_done),
    .br_taken      (br_taken),
    .br_illegal    (br_illegal),
    .cnt_branches  (cnt_branches),
    .cnt_taken     (cnt_taken)
  );

  // External comparator
  assign cmp_BrEq = (cmp_num1 == cmp_num2);
  assign cmp_BrLt = cmp_BrUn ? (cmp_num1 < cmp_num2) : ($signed(cmp_num1) < $signed(cmp_num2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns at T+1 (+1 time unit) where T is the accept cycle.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm);
    @(posedge clk); #1;
    br_valid = 1'b1; br_funct3 = f3; br_rs1 = a; br_rs2 = b; br_pc = pc; br_imm = imm;
    @(posedge clk); #1;
    br_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!br_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!br_ready) check("idle_timeout", 32'(br_ready), 1);
  endtask

  typedef struct {logic [2:0] f3; logic [31:0] a; logic [31:0] b; logic tk;} vec_t;
  vec_t vecs[8];

  initial begin
    vecs[0] = '{3'b000, 32'd1, 32'd2, 1'b0};
    vecs[1] = '{3'b001, 32'd3, 32'd3, 1'b0};
    vecs[2] = '{3'b001, 32'd3, 32'd4, 1'b1};
    vecs[3] = '{3'b101, 32'hFFFF_FFFF, 32'd1, 1'b0};
    vecs[4] = '{3'b101, 32'd5, 32'd5, 1'b1};
    vecs[5] = '{3'b111, 32'd0, 32'hFFFF_FFFF, 1'b0};
    vecs[6] = '{3'b110, 32'd0, 32'hFFFF_FFFF, 1'b1};
    vecs[7] = '{3'b011, 32'd0, 32'd0, 1'b0};

    rst = 1'b1; br_valid = 1'b0; br_funct3 = '0;
    br_rs1 = '0; br_rs2 = '0; br_pc = '0; br_imm = '0; redirect_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(br_ready), 1);
    check("rst_rvalid", 32'(redirect_valid), 0);
    check("rst_flush", 32'(flush), 0);
    check("rst_done", 32'(br_done), 0);
    check("rst_cnt", 32'(cnt_branches), 0);

    // BEQ taken with full redirect and flush timing
    issue(3'b000, 32'd5, 32'd5, 32'h100, 32'h20);
    @(negedge clk);  // T+1
    check("beq_t1_ready", 32'(br_ready), 0);
    check("beq_t1_done", 32'(br_done), 0);
    check("beq_num1", cmp_num1, 32'd5);
    @(negedge clk);  // T+2
    check("beq_done", 32'(br_done), 1);
    check("beq_taken", 32'(br_taken), 1);
    check("beq_illegal", 32'(br_illegal), 0);
    @(negedge clk);  // T+3
    check("beq_rvalid", 32'(redirect_valid), 1);
    check("beq_rpc", redirect_pc, 32'h120);
    check("beq_t3_flush", 32'(flush), 0);
    check("beq_cntb", 32'(cnt_branches), 1);
    check("beq_cntt", 32'(cnt_taken), 1);
    @(negedge clk);  // T+4
    check("beq_flush4", 32'(flush), 1);
    check("beq_rvalid4", 32'(redirect_valid), 0);
    @(negedge clk);  // T+5
    check("beq_flush5", 32'(flush), 1);
    @(negedge clk);  // T+6
    check("beq_flush6", 32'(flush), 0);
    check("beq_ready6", 32'(br_ready), 1);

    // BLT signed: -1 < 1 taken
    issue(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h8);
    @(negedge clk);
    check("blt_brun", 32'(cmp_BrUn), 0);
    @(negedge clk);
    check("blt_taken", 32'(br_taken), 1);
    wait_idle();

    // BLTU same operands: 0xFFFFFFFF < 1 false
    issue(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h8);
    @(negedge clk);
    check("bltu_brun", 32'(cmp_BrUn), 1);
    @(negedge clk);
    check("bltu_done", 32'(br_done), 1);
    check("bltu_taken", 32'(br_taken), 0);
    @(negedge clk);  // T+3
    check("bltu_ready", 32'(br_ready), 1);
    check("bltu_rvalid", 32'(redirect_valid), 0);
    check("bltu_flush", 32'(flush), 0);

    // BGEU taken with redirect stall
    redirect_ready = 1'b0;
    issue(3'b111, 32'd10, 32'd3, 32'h200, 32'h40);
    @(negedge clk);
    @(negedge clk);
    check("bgeu_taken", 32'(br_taken), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bgeu_stall_rvalid", 32'(redirect_valid), 1);
      check("bgeu_stall_rpc", redirect_pc, 32'h240);
      check("bgeu_stall_flush", 32'(flush), 0);
    end
    @(posedge clk); #1 redirect_ready = 1'b1;
    @(negedge clk);
    check("bgeu_hs_rvalid", 32'(redirect_valid), 1);
    @(negedge clk);
    check("bgeu_post_flush", 32'(flush), 1);
    check("bgeu_post_rvalid", 32'(redirect_valid), 0);
    wait_idle();

    // Illegal funct3 with equal operands: never taken
    issue(3'b010, 32'd7, 32'd7, 32'h0, 32'h4);
    @(negedge clk);
    @(negedge clk);
    check("ill_done", 32'(br_done), 1);
    check("ill_illegal", 32'(br_illegal), 1);
    check("ill_taken", 32'(br_taken), 0);
    @(negedge clk);
    check("ill_cntb", 32'(cnt_branches), 5);
    check("ill_cntt", 32'(cnt_taken), 3);
    check("ill_ready", 32'(br_ready), 1);

    // PC wrap, then reset while parked in REDIR
    redirect_ready = 1'b0;
    issue(3'b001, 32'd1, 32'd2, 32'hFFFF_FFF0, 32'h20);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("wrap_rvalid", 32'(redirect_valid), 1);
    check("wrap_rpc", redirect_pc, 32'h10);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    redirect_ready = 1'b1;
    @(negedge clk);
    check("rstr_ready", 32'(br_ready), 1);
    check("rstr_rvalid", 32'(redirect_valid), 0);
    check("rstr_flush", 32'(flush), 0);
    check("rstr_cntb", 32'(cnt_branches), 0);
    check("rstr_cntt", 32'(cnt_taken), 0);

    // funct3 decode table
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].f3, vecs[i].a, vecs[i].b, 32'h400, 32'h10);
      @(negedge clk);
      @(negedge clk);
      check("tbl_taken", 32'(br_taken), 32'(vecs[i].tk));
      wait_idle();
    end
    check("tbl_cntb", 32'(cnt_branches), 8);
    check("tbl_cntt", 32'(cnt_taken), 3);

    // Counter saturation: 2^CntW+3 taken branches from 8/3
    for (int i = 0; i < (1 << CntW) + 3; i++) begin
      issue(3'b000, 32'd9, 32'd9, 32'h0, 32'h4);
      wait_idle();
    end
    check("sat_cntb", 32'(cnt_branches), 32'hF);
    check("sat_cntt", 32'(cnt_taken), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
